// File: rtl/master_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// master_tx : open-drain bit-slot transmitter (write-1 / write-0) with a
// pull-up bus model; MASTER_TX_DONE_EN adds a one-cycle done pulse. Rev 1.0
// ---------------------------------------------------------------------------

module master_tx_bus (
    input  logic drive_low_i,
    output wire  line_o
);
    // Resolved level of the pulled-up line: only ever pulled to 0, never driven 1.
    logic bus;

    assign bus    = ~drive_low_i;
    assign line_o = bus ? 1'bz : 1'b0;
endmodule

module master_tx #(
    parameter int T_LOW1 = 6,
    parameter int T_LOW0 = 60,
    parameter int T_SLOT = 70
) (
    input  logic clk,
    input  logic rst,
    input  logic ready,
    input  logic bit_to_send,
    output wire  bus_out
`ifdef MASTER_TX_DONE_EN
    ,
    output logic done
`endif
);
    localparam int CNT_W = $clog2(T_SLOT + 1);
    localparam logic [CNT_W-1:0] C_LOW1 = CNT_W'(T_LOW1);
    localparam logic [CNT_W-1:0] C_LOW0 = CNT_W'(T_LOW0);
    localparam logic [CNT_W-1:0] C_SLOT = CNT_W'(T_SLOT);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOW     = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             bit_q;
    logic             drive_low_q;
    logic             start_d;
    logic [CNT_W-1:0] low_len_d;
`ifdef MASTER_TX_DONE_EN
    logic             done_q;
`endif

    // Unknown ready/data compare as false, so X inputs never open a slot.
    assign start_d   = (ready == 1'b1) && ((bit_to_send == 1'b1) || (bit_to_send == 1'b0));
    assign low_len_d = bit_q ? C_LOW1 : C_LOW0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= 1'b0;
            drive_low_q <= 1'b0;
`ifdef MASTER_TX_DONE_EN
            done_q      <= 1'b0;
`endif
        end else begin
`ifdef MASTER_TX_DONE_EN
            done_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (start_d) begin
                        state_q     <= S_LOW;
                        cnt_q       <= C_ONE;
                        bit_q       <= bit_to_send;
                        drive_low_q <= 1'b1;
                    end
                end
                S_LOW: begin
                    cnt_q <= cnt_q + C_ONE;
                    if (cnt_q == low_len_d) begin
                        state_q     <= S_RELEASE;
                        drive_low_q <= 1'b0;
                    end
                end
                S_RELEASE: begin
                    if (cnt_q == C_SLOT) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
`ifdef MASTER_TX_DONE_EN
                        done_q  <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + C_ONE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cnt_q       <= '0;
                    drive_low_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef MASTER_TX_DONE_EN
    assign done = done_q;
`endif

    master_tx_bus bus (
        .drive_low_i (drive_low_q),
        .line_o      (bus_out)
    );
endmodule

`default_nettype wire

// File: tb/tb_master_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_master_tx : randomized self-checking bench for master_tx against a
// slot-position reference model. Rev 1.0
// ---------------------------------------------------------------------------

module tb_master_tx;
    localparam int T_LOW1 = 6;
    localparam int T_LOW0 = 60;
    localparam int T_SLOT = 70;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ready = 1'b0;
    logic bit_to_send = 1'b1;
    tri1  bus_line;
`ifdef MASTER_TX_DONE_EN
    logic done;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    // Reference model: position inside the current slot (-1 = idle).
    int   m_pos  = -1;
    logic m_bit  = 1'b0;
    logic m_done = 1'b0;

    master_tx #(.T_LOW1(T_LOW1), .T_LOW0(T_LOW0), .T_SLOT(T_SLOT)) dut (
        .clk         (clk),
        .rst         (rst),
        .ready       (ready),
        .bit_to_send (bit_to_send),
        .bus_out     (bus_line)
`ifdef MASTER_TX_DONE_EN
        ,
        .done        (done)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic exp_line();
        int low_len;
        low_len = m_bit ? T_LOW1 : T_LOW0;
        return (m_pos >= 0 && m_pos < low_len) ? 1'b0 : 1'b1;
    endfunction

    task automatic tick(input logic r, input logic b);
        ready       = r;
        bit_to_send = b;
        @(posedge clk);
        if (!rst) begin
            m_pos  = -1;
            m_done = 1'b0;
        end else if (m_pos >= 0) begin
            m_pos  = m_pos + 1;
            m_done = 1'b0;
            if (m_pos == T_SLOT) begin
                m_pos  = -1;
                m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (r) begin
                m_pos = 0;
                m_bit = b;
            end
        end
        cyc = cyc + 1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b1);
            n_total++;
            if (bus_line !== 1'b1) $display("FAIL reset_line cyc%0d got %b exp 1", i, bus_line);
            else n_pass++;
            n_total++;
            if (dut.bus.bus !== 1'b1) $display("FAIL reset_busnet cyc%0d got %b exp 1", i, dut.bus.bus);
            else n_pass++;
`ifdef MASTER_TX_DONE_EN
            n_total++;
            if (done !== 1'b0) $display("FAIL reset_done cyc%0d got %b exp 0", i, done);
            else n_pass++;
`endif
        end
        rst = 1'b1;
    endtask

    task automatic test_write1();
        int lows = 0;
        for (int i = 0; i < T_SLOT; i++) begin
            tick(1'b1, 1'b1);
            n_total++;
            if (bus_line !== exp_line()) $display("FAIL write1_line slotcyc%0d got %b exp %b", i, bus_line, exp_line());
            else n_pass++;
            n_total++;
            if (dut.bus.bus !== exp_line()) $display("FAIL write1_busnet slotcyc%0d got %b exp %b", i, dut.bus.bus, exp_line());
            else n_pass++;
            if (bus_line === 1'b0) lows++;
        end
        n_total++;
        if (lows !== T_LOW1) $display("FAIL write1_lowcount got %0d exp %0d", lows, T_LOW1);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lows = 0;
        // single idle cycle between slots, data switched to 0 here
        tick(1'b1, 1'b0);
        n_total++;
        if (bus_line !== 1'b1) $display("FAIL b2b_idle_line got %b exp 1", bus_line);
        else n_pass++;
`ifdef MASTER_TX_DONE_EN
        n_total++;
        if (done !== 1'b1) $display("FAIL b2b_idle_done got %b exp 1", done);
        else n_pass++;
`endif
        for (int i = 0; i < T_SLOT; i++) begin
            tick(1'b1, 1'b0);
            n_total++;
            if (bus_line !== exp_line()) $display("FAIL write0_line slotcyc%0d got %b exp %b", i, bus_line, exp_line());
            else n_pass++;
            if (bus_line === 1'b0) lows++;
        end
        n_total++;
        if (lows !== T_LOW0) $display("FAIL write0_lowcount got %0d exp %0d", lows, T_LOW0);
        else n_pass++;
    endtask

    task automatic test_ignore_inputs();
        int lows = 0;
        tick(1'b1, 1'b1);
        for (int i = 0; i < T_SLOT; i++) begin
            tick(1'($urandom_range(0, 1)), (i < 3) ? 1'b1 : 1'b0);
            n_total++;
            if (bus_line !== exp_line()) $display("FAIL ignore_line slotcyc%0d got %b exp %b", i, bus_line, exp_line());
            else n_pass++;
            if (bus_line === 1'b0) lows++;
        end
        n_total++;
        if (lows !== T_LOW1) $display("FAIL ignore_lowcount got %0d exp %0d", lows, T_LOW1);
        else n_pass++;
        tick(1'b0, 1'b0);
        n_total++;
        if (bus_line !== 1'b1) $display("FAIL ignore_slotend_line got %b exp 1", bus_line);
        else n_pass++;
    endtask

    task automatic test_reset_midslot();
        int lows = 0;
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        for (int i = 1; i < 30; i++) tick(1'b1, 1'b0);
        n_total++;
        if (bus_line !== 1'b0) $display("FAIL midrst_pre_line got %b exp 0", bus_line);
        else n_pass++;
        #1;
        rst = 1'b0;
        m_pos = -1;
        #1;
        n_total++;
        if (bus_line !== 1'b1) $display("FAIL midrst_async_line got %b exp 1", bus_line);
        else n_pass++;
        n_total++;
        if (dut.bus.bus !== 1'b1) $display("FAIL midrst_async_busnet got %b exp 1", dut.bus.bus);
        else n_pass++;
        tick(1'b1, 1'b0);
        n_total++;
        if (bus_line !== 1'b1) $display("FAIL midrst_held_line got %b exp 1", bus_line);
        else n_pass++;
        rst = 1'b1;
        tick(1'b0, 1'b1);
        n_total++;
        if (bus_line !== 1'b1) $display("FAIL midrst_noresume_line got %b exp 1", bus_line);
        else n_pass++;
        for (int i = 0; i < T_SLOT; i++) begin
            tick(1'b1, 1'b0);
            n_total++;
            if (bus_line !== exp_line()) $display("FAIL midrst_next_line slotcyc%0d got %b exp %b", i, bus_line, exp_line());
            else n_pass++;
            if (bus_line === 1'b0) lows++;
        end
        n_total++;
        if (lows !== T_LOW0) $display("FAIL midrst_next_lowcount got %0d exp %0d", lows, T_LOW0);
        else n_pass++;
        tick(1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            n_total++;
            if (bus_line !== exp_line()) $display("FAIL random_line cyc%0d got %b exp %b", cyc, bus_line, exp_line());
            else n_pass++;
            n_total++;
            if (dut.bus.bus !== exp_line()) $display("FAIL random_busnet cyc%0d got %b exp %b", cyc, dut.bus.bus, exp_line());
            else n_pass++;
`ifdef MASTER_TX_DONE_EN
            n_total++;
            if (done !== m_done) $display("FAIL random_done cyc%0d got %b exp %b", cyc, done, m_done);
            else n_pass++;
`endif
        end
    endtask

`ifdef MASTER_TX_DONE_EN
    task automatic test_done_spacing();
        int last_done = -1;
        int pulses    = 0;
        for (int i = 0; i < 4 * (T_SLOT + 1) + 2; i++) begin
            tick(1'b1, 1'($urandom_range(0, 1)));
            if (done === 1'b1) begin
                if (last_done >= 0) begin
                    n_total++;
                    if (cyc - last_done !== T_SLOT + 1)
                        $display("FAIL done_spacing got %0d exp %0d", cyc - last_done, T_SLOT + 1);
                    else n_pass++;
                end
                last_done = cyc;
                pulses++;
            end
        end
        n_total++;
        if (pulses < 3) $display("FAIL done_pulsecount got %0d exp >=3", pulses);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_write1();
        test_back_to_back();
        test_ignore_inputs();
        test_reset_midslot();
        test_random();
`ifdef MASTER_TX_DONE_EN
        test_done_spacing();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

`default_nettype wire
